// File: rtl/gpio_irq_pkg.sv
// rtl/gpio_irq_pkg.sv - register map and interrupt type encodings for gpio_irq
package gpio_irq_pkg;

    localparam logic [2:0] REG_IN    = 3'd0;
    localparam logic [2:0] REG_IT0   = 3'd1;
    localparam logic [2:0] REG_IT1   = 3'd2;
    localparam logic [2:0] REG_DBEN  = 3'd3;
    localparam logic [2:0] REG_DBDIV = 3'd4;
    localparam int         REG_COUNT = 5;

    // Per-pin type is {IT1[i], IT0[i]}
    typedef enum logic [1:0] {
        IRQ_RISE  = 2'b00,
        IRQ_FALL  = 2'b01,
        IRQ_BOTH  = 2'b10,
        IRQ_LEVEL = 2'b11
    } irq_type_e;

endpackage

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - per-pin synchronizer, tick-based debounce counter and filtered level
module gpio_debounce (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    input  logic tick,
    input  logic dben,
    output logic filt
);

    logic       sync1;
    logic       sync;
    logic [1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync  <= 1'b0;
            filt  <= 1'b0;
            cnt   <= 2'd0;
        end else begin
            sync1 <= pin;
            sync  <= sync1;
            if (!dben) begin
                filt <= sync;
                cnt  <= 2'd0;
            end else if (sync == filt) begin
                cnt <= 2'd0;
            end else if (tick) begin
                // Third tick of a sustained difference accepts the new level
                if (cnt == 2'd2) begin
                    filt <= sync;
                    cnt  <= 2'd0;
                end else begin
                    cnt <= cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/gpio_irq.sv
// rtl/gpio_irq.sv - GPIO input block with debounce, CSR window and per-pin edge/level interrupts
module gpio_irq
    import gpio_irq_pkg::*;
#(
    parameter logic [4:0] BASE_ADDR = 5'b0,
    parameter int         NUM_PINS  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4:0]          csr_a,
    input  logic [7:0]          csr_di,
    input  logic                csr_we,
    output logic [7:0]          csr_do,
    input  logic [NUM_PINS-1:0] pins_in,
    output logic [NUM_PINS-1:0] irqs_out
);

    logic [NUM_PINS-1:0] it0;
    logic [NUM_PINS-1:0] it1;
    logic [NUM_PINS-1:0] dben;
    logic [NUM_PINS-1:0] filt;
    logic [NUM_PINS-1:0] filt_d;
    logic [NUM_PINS-1:0] irq_next;
    logic [7:0]          dbdiv;
    logic [7:0]          pre;
    logic                tick;
    logic [1:0]          startup;
    logic                armed;
    logic [5:0]          offset;
    logic                in_win;
    logic [2:0]          sel;
    logic                wr;

    // Widened subtract so addresses below the base never alias into the window
    assign offset = {1'b0, csr_a} - {1'b0, BASE_ADDR};
    assign in_win = offset < 6'(REG_COUNT);
    assign sel    = offset[2:0];
    assign wr     = csr_we && in_win;
    assign tick   = (pre == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            it0   <= '0;
            it1   <= '0;
            dben  <= '0;
            dbdiv <= 8'd0;
        end else if (wr) begin
            case (sel)
                REG_IT0:   it0   <= csr_di[NUM_PINS-1:0];
                REG_IT1:   it1   <= csr_di[NUM_PINS-1:0];
                REG_DBEN:  dben  <= csr_di[NUM_PINS-1:0];
                REG_DBDIV: dbdiv <= csr_di;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= 8'd0;
        end else if (wr && sel == REG_DBDIV) begin
            pre <= csr_di;
        end else if (tick) begin
            pre <= dbdiv;
        end else begin
            pre <= pre - 8'd1;
        end
    end

    always_comb begin
        csr_do = 8'd0;
        if (in_win) begin
            case (sel)
                REG_IN:    csr_do = 8'(filt);
                REG_IT0:   csr_do = 8'(it0);
                REG_IT1:   csr_do = 8'(it1);
                REG_DBEN:  csr_do = 8'(dben);
                REG_DBDIV: csr_do = dbdiv;
                default:   csr_do = 8'd0;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
        gpio_debounce u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .pin   (pins_in[i]),
            .tick  (tick),
            .dben  (dben[i]),
            .filt  (filt[i])
        );
    end

    always_comb begin
        irq_next = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            case (irq_type_e'({it1[i], it0[i]}))
                IRQ_RISE:  irq_next[i] = armed && filt[i] && !filt_d[i];
                IRQ_FALL:  irq_next[i] = armed && !filt[i] && filt_d[i];
                IRQ_BOTH:  irq_next[i] = armed && (filt[i] != filt_d[i]);
                IRQ_LEVEL: irq_next[i] = filt[i];
                default:   irq_next[i] = 1'b0;
            endcase
        end
    end

    // armed lags the saturated startup count so the first filt change after reset is masked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_d   <= '0;
            irqs_out <= '0;
            startup  <= 2'd0;
            armed    <= 1'b0;
        end else begin
            filt_d   <= filt;
            irqs_out <= irq_next;
            if (startup != 2'd3) begin
                startup <= startup + 2'd1;
            end
            armed <= (startup == 2'd3);
        end
    end

endmodule
